// File: rtl/fetch_stage_if.sv
// Fetch-stage handshake bundle: hazard/ID controls in, imem address and IF/ID out.
// master drives controls and imem data; slave is the fetch stage.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             pc_enable;
  logic             instr_enable;
  logic             pc_src;
  logic             jumpD;
  logic [31:0]      branch_targetD;
  logic [31:0]      jump_targetD;
  logic [31:0]      imem_rdata;
  logic [31:0]      imem_addr;
  logic [31:0]      instrD;
  logic [31:0]      pc_plus4D;
  logic             validD;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output pc_enable,
    output instr_enable,
    output pc_src,
    output jumpD,
    output branch_targetD,
    output jump_targetD,
    output imem_rdata,
    input  imem_addr,
    input  instrD,
    input  pc_plus4D,
    input  validD,
    input  stall_count,
    input  flush_count
  );

  modport slave (
    input  pc_enable,
    input  instr_enable,
    input  pc_src,
    input  jumpD,
    input  branch_targetD,
    input  jump_targetD,
    input  imem_rdata,
    output imem_addr,
    output instrD,
    output pc_plus4D,
    output validD,
    output stall_count,
    output flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
// and saturating stall/flush debug counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc_plus4;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_jump_pc;
  logic [31:0] w_branch_pc;
  logic        w_redirect;
  logic        w_hold;
  logic        w_take_jump;
  logic        w_take_branch;
  logic        w_seq;
  logic        w_if_hold;
  logic        w_if_flush;
  logic        w_if_load;
  logic        w_unused;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_jump_pc   = {bus.jump_targetD[31:2], 2'b00};
  assign w_branch_pc = {bus.branch_targetD[31:2], 2'b00};
  assign w_redirect  = bus.pc_src | bus.jumpD;

  // One-hot select terms so the decoders below stay unique.
  assign w_hold        = ~bus.pc_enable;
  assign w_take_jump   = bus.pc_enable & bus.jumpD;
  assign w_take_branch = bus.pc_enable & ~bus.jumpD & bus.pc_src;
  assign w_seq         = bus.pc_enable & ~bus.jumpD & ~bus.pc_src;

  assign w_if_hold  = ~bus.instr_enable;
  assign w_if_flush = bus.instr_enable & w_redirect;
  assign w_if_load  = bus.instr_enable & ~w_redirect;

  always_comb begin
    w_pc_next = r_pc;
    unique case (1'b1)
      w_hold:        w_pc_next = r_pc;
      w_take_jump:   w_pc_next = w_jump_pc;
      w_take_branch: w_pc_next = w_branch_pc;
      w_seq:         w_pc_next = w_pc_plus4;
      default:       w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      unique case (1'b1)
        w_if_hold: begin
          r_instr    <= r_instr;
          r_pc_plus4 <= r_pc_plus4;
          r_valid    <= r_valid;
        end
        w_if_flush: begin
          r_instr    <= 32'h0;
          r_pc_plus4 <= 32'h0;
          r_valid    <= 1'b0;
        end
        w_if_load: begin
          r_instr    <= bus.imem_rdata;
          r_pc_plus4 <= w_pc_plus4;
          r_valid    <= 1'b1;
        end
        default: begin
          r_instr    <= r_instr;
          r_pc_plus4 <= r_pc_plus4;
          r_valid    <= r_valid;
        end
      endcase
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_if_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.instrD      = r_instr;
  assign bus.pc_plus4D   = r_pc_plus4;
  assign bus.validD      = r_valid;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

  assign w_unused = ^{bus.jump_targetD[1:0], bus.branch_targetD[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan plus random traffic against a
// cycle-level reference model; a second instance covers wrap and saturation.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.CNT_W(32)) ia ();
  fetch_stage_if #(.CNT_W(3))  ib ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) u_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (ia)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFFC),
    .CNT_W   (3)
  ) u_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (ib)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A00_00C3;
  endfunction

  assign ia.imem_rdata = word(ia.imem_addr);
  assign ib.imem_rdata = word(ib.imem_addr);

  logic [31:0] m_pc, m_instr, m_p4, m_stall, m_flush;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  ia.imem_addr, m_pc);
    chk({tag, ".instr"}, ia.instrD, m_instr);
    chk({tag, ".p4"},    ia.pc_plus4D, m_p4);
    chk({tag, ".valid"}, {31'b0, ia.validD}, {31'b0, m_valid});
    chk({tag, ".stall"}, ia.stall_count, m_stall);
    chk({tag, ".flush"}, ia.flush_count, m_flush);
  endtask

  // Advance one clock; the model steps from the inputs held across the edge.
  task automatic cycle();
    logic [31:0] n_pc, n_instr, n_p4, n_stall, n_flush;
    logic        n_valid;
    n_pc = m_pc; n_instr = m_instr; n_p4 = m_p4;
    n_valid = m_valid; n_stall = m_stall; n_flush = m_flush;
    if (rst_a) begin
      n_pc = 0; n_instr = 0; n_p4 = 0;
      n_valid = 0; n_stall = 0; n_flush = 0;
    end else begin
      if (!ia.pc_enable) begin
        if (m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
      end else if (ia.jumpD) begin
        n_pc = ia.jump_targetD & 32'hFFFF_FFFC;
      end else if (ia.pc_src) begin
        n_pc = ia.branch_targetD & 32'hFFFF_FFFC;
      end else begin
        n_pc = m_pc + 4;
      end
      if (ia.instr_enable) begin
        if (ia.pc_src || ia.jumpD) begin
          n_instr = 0; n_p4 = 0; n_valid = 0;
          if (m_flush != 32'hFFFF_FFFF) n_flush = m_flush + 1;
        end else begin
          n_instr = word(m_pc); n_p4 = m_pc + 4; n_valid = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_p4 = n_p4;
    m_valid = n_valid; m_stall = n_stall; m_flush = n_flush;
  endtask

  task automatic drive_a(input logic pe, input logic ie, input logic ps,
                         input logic jd, input logic [31:0] bt,
                         input logic [31:0] jt);
    ia.pc_enable = pe; ia.instr_enable = ie;
    ia.pc_src = ps; ia.jumpD = jd;
    ia.branch_targetD = bt; ia.jump_targetD = jt;
  endtask

  task automatic drive_b(input logic pe, input logic ie, input logic ps);
    ib.pc_enable = pe; ib.instr_enable = ie;
    ib.pc_src = ps; ib.jumpD = 1'b0;
    ib.branch_targetD = 32'h0000_0020; ib.jump_targetD = 32'h0;
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1, 1, 0, 0, 0, 0);
    drive_b(1, 1, 0);
    cycle();
    cycle();
    chk_all("reset");
    chk("reset.pc", ia.imem_addr, 32'h0);
    chk("b.reset.pc", ib.imem_addr, 32'hFFFF_FFFC);

    // Free run
    rst_a = 1'b0;
    rst_b = 1'b0;
    cycle();
    chk_all("run1");
    chk("run1.pc", ia.imem_addr, 32'h4);
    chk("run1.instr", ia.instrD, word(32'h0));
    chk("b.wrap.pc", ib.imem_addr, 32'h0);
    chk("b.wrap.p4", ib.pc_plus4D, 32'h0);
    chk("b.wrap.instr", ib.instrD, word(32'hFFFF_FFFC));
    cycle();
    chk_all("run2");
    chk("run2.pc", ia.imem_addr, 32'h8);

    // Load-use stall at pc=8
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0);
    cycle();
    chk_all("stall");
    chk("stall.pc", ia.imem_addr, 32'h8);
    chk("stall.instr", ia.instrD, word(32'h4));
    chk("stall.cnt", ia.stall_count, 32'd1);
    drive_a(1, 1, 0, 0, 0, 0);
    cycle();
    chk_all("resume");
    chk("resume.pc", ia.imem_addr, 32'hC);
    cycle();
    chk("pre_br.pc", ia.imem_addr, 32'h10);

    // Taken branch at pc=0x10
    drive_a(1, 1, 1, 0, 32'h40, 32'h0);
    cycle();
    chk_all("branch");
    chk("branch.pc", ia.imem_addr, 32'h40);
    chk("branch.instr", ia.instrD, 32'h0);
    chk("branch.flush", ia.flush_count, 32'd1);
    drive_a(1, 1, 0, 0, 0, 0);
    cycle();
    chk_all("tgt");
    chk("tgt.instr", ia.instrD, word(32'h40));
    chk("tgt.p4", ia.pc_plus4D, 32'h44);

    // Jump beats branch; misaligned jump target is forced aligned
    drive_a(1, 1, 1, 1, 32'h200, 32'h100);
    cycle();
    chk_all("jmpbr");
    chk("jmpbr.pc", ia.imem_addr, 32'h100);
    drive_a(1, 1, 1, 1, 32'h200, 32'h103);
    cycle();
    chk_all("jmpmis");
    chk("jmpmis.pc", ia.imem_addr, 32'h100);

    // PC advances while IF/ID holds
    drive_a(1, 0, 0, 0, 0, 0);
    cycle();
    chk_all("ifhold");

    // Redirect during hold neither flushes nor counts
    drive_a(0, 0, 0, 1, 32'h0, 32'h300);
    cycle();
    chk_all("holdredir");

    // Stall the wrap instance long enough to saturate its 3-bit counter
    for (int i = 0; i < 10; i++) begin
      cycle();
    end
    chk("b.stall_sat", {29'b0, ib.stall_count}, 32'd7);
    drive_b(1, 1, 1);
    for (int i = 0; i < 9; i++) begin
      cycle();
    end
    chk("b.flush_sat", {29'b0, ib.flush_count}, 32'd7);
    chk("b.flush_pc", ib.imem_addr, 32'h20);
    chk_all("longhold");

    // Reset during a stall with a pending redirect
    drive_a(0, 0, 1, 0, 32'h80, 32'h0);
    rst_a = 1'b1;
    cycle();
    chk_all("midrst");
    chk("midrst.pc", ia.imem_addr, 32'h0);
    chk("midrst.stall", ia.stall_count, 32'd0);
    chk("midrst.flush", ia.flush_count, 32'd0);
    rst_a = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic pe, ie;
      pe = ($urandom_range(0, 3) != 0);
      ie = pe ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      drive_a(pe, ie, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
              $urandom, $urandom);
      rst_a = ($urandom_range(0, 60) == 0);
      cycle();
      chk_all("rand");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the stall/flush controls produced by the hazard unit (pc_enable, instr_enable) plus the redirect signals resolved in ID (pc_src, jumpD).
- Drives the instruction-memory address and delivers instrD / pc_plus4D to decode.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 0)
CNT_W, 32, width of stall_count and flush_count

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_enable  input  1  1 = PC may update; 0 = hold PC (load-use stall)
instr_enable  input  1  1 = IF/ID may update; 0 = hold IF/ID
pc_src  input  1  branch taken, resolved in ID
jumpD  input  1  jump instruction in ID
branch_targetD  input  32  branch target address from ID
jump_targetD  input  32  jump target address from ID
imem_rdata  input  32  instruction word at imem_addr (combinational read, same cycle)
imem_addr  output  32  current PC, to instruction memory
instrD  output  32  IF/ID instruction
pc_plus4D  output  32  IF/ID PC+4
validD  output  1  IF/ID holds a real (non-flushed) instruction
stall_count  output  CNT_W  cycles with pc_enable==0
flush_count  output  CNT_W  IF/ID flush events

Behaviour:
- Reset (sampled at rising clk while reset==1):
  - pc <= RESET_PC.
  - instrD, pc_plus4D, validD, stall_count, flush_count <= 0.
  - Reset overrides every other input and is valid mid-stall or mid-redirect.
- imem_addr = pc, combinationally. pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Next-PC, evaluated each non-reset edge in priority order:
  1. pc_enable==0 -> pc holds.
  2. jumpD==1 -> pc <= {jump_targetD[31:2], 2'b00}.
  3. pc_src==1 -> pc <= {branch_targetD[31:2], 2'b00}.
  4. Otherwise -> pc <= pc_plus4.
  - Jump has priority over branch when both are asserted.
  - Target low bits are always forced to 00; pc[1:0] is never nonzero.
- IF/ID register, evaluated each non-reset edge in priority order:
  1. instr_enable==0 -> instrD, pc_plus4D and validD hold.
  2. pc_src | jumpD -> flush: instrD <= 32'h0 (nop), pc_plus4D <= 0, validD <= 0.
  3. Otherwise -> instrD <= imem_rdata, pc_plus4D <= pc_plus4, validD <= 1.
- Latency:
  - Fetched word appears on instrD one cycle after its PC is on imem_addr.
  - A redirect costs exactly one flushed slot: the target is on imem_addr in cycle N+1 and on instrD in cycle N+2.
- pc_enable and instr_enable act independently. The combination pc_enable=1 with instr_enable=0 is not produced by the hazard unit; if it occurs, the PC advances while IF/ID holds. The bench covers it, but no assertion fires.
- stall_count:
  - +1 on each non-reset edge where pc_enable==0.
  - Saturates at 2^CNT_W-1 with no wrap.
- flush_count:
  - +1 on each non-reset edge where instr_enable==1 and (pc_src|jumpD).
  - Saturates at 2^CNT_W-1.
  - A redirect asserted during a hold (instr_enable==0) is not counted and does not flush.
- Pure synchronous design: no latches, no combinational path from any input to any registered output. imem_addr depends only on pc.

Test Plan:
- Reset then free-run, imem returning addr-tagged words -> imem_addr sequence 0,4,8,12; instrD lags one cycle; validD=1 from the second edge; counters remain 0.
- Load-use stall: pc_enable=instr_enable=0 for 1 cycle at pc=8 -> pc holds at 8, instrD holds the word from addr 4, stall_count=1; fetch resumes at 12 on the next cycle.
- Taken branch at pc=0x10, branch_targetD=0x40 -> next imem_addr=0x40; instrD=0, validD=0 for one cycle; then the word from 0x40 with pc_plus4D=0x44; flush_count=1.
- Jump and branch asserted together, jump_targetD=0x100, branch_targetD=0x200, plus a misaligned jump_targetD=0x103 case -> pc=0x100 in both cases.
- Wrap and saturation: RESET_PC=0xFFFF_FFFC -> next pc=0. With CNT_W=3, hold pc_enable=0 for 10 cycles -> stall_count stops at 7.
- Reset asserted for one cycle during a stall with a pending redirect -> pc=RESET_PC; instrD, validD and both counters=0 on the following edge.
